noc_mmio_bridge: RTL and testbench

Memory-mapped bridge between a picorv32 node's look-ahead memory bus and its Hoplite router port. Next-generation replacement for the hard-wired single-message IO decode in each processing node: buffered TX and RX message FIFOs of parametric depth, per-message destination coordinates, a parametric LED register, coordinate readback and sticky error status. Sits beside the node's local RAM; the node's top level multiplexes `rdata` onto `mem_rdata` when `hit` was asserted on the previous cycle.

---
 rtl/noc_mmio_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_noc_mmio_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/noc_mmio_bridge.sv
// noc_mmio_bridge: MMIO register window between a picorv32 look-ahead bus and a
// Hoplite router port, with buffered TX/RX message FIFOs, LED register, coordinate
// readback and sticky error flags. Optional feature macro: NOC_MMIO_IRQ_EN adds the
// IRQ_EN register and a registered RX-non-empty interrupt.
module noc_mmio_bridge #(
    parameter int          COORD_BITS = 1,
    parameter int          X_COORD    = 0,
    parameter int          Y_COORD    = 0,
    parameter int          TX_DEPTH   = 4,
    parameter int          RX_DEPTH   = 4,
    parameter int          LED_COUNT  = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_la_read,
    input  logic                  mem_la_write,
    input  logic [31:0]           mem_la_addr,
    input  logic [31:0]           mem_la_wdata,
    output logic                  hit,
    output logic [31:0]           rdata,
    output logic [31:0]           tx_data,
    output logic [COORD_BITS-1:0] tx_x_dest,
    output logic [COORD_BITS-1:0] tx_y_dest,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [31:0]           rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [LED_COUNT-1:0]  led,
    output logic                  irq
);
    localparam int TX_PW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_PW + 1;
    localparam int RX_PW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_PW + 1;
    localparam int TX_W  = 32 + 2 * COORD_BITS;
    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [COORD_BITS-1:0] MY_X = COORD_BITS'(X_COORD);
    localparam logic [COORD_BITS-1:0] MY_Y = COORD_BITS'(Y_COORD);

    localparam logic [2:0] REG_TX_X    = 3'd0;
    localparam logic [2:0] REG_TX_Y    = 3'd1;
    localparam logic [2:0] REG_TX_DATA = 3'd2;
    localparam logic [2:0] REG_RX_DATA = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;
    localparam logic [2:0] REG_COORD   = 3'd5;
    localparam logic [2:0] REG_LED     = 3'd6;
    localparam logic [2:0] REG_IRQ_EN  = 3'd7;

    logic [COORD_BITS-1:0] tx_x_q, tx_x_d, tx_y_q, tx_y_d;
    logic [TX_W-1:0]       tx_mem_q [TX_DEPTH];
    logic [TX_W-1:0]       tx_mem_d [TX_DEPTH];
    logic [TX_PW-1:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [31:0]           rx_mem_q [RX_DEPTH];
    logic [31:0]           rx_mem_d [RX_DEPTH];
    logic [RX_PW-1:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic                  tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
    logic [LED_COUNT-1:0]  led_q, led_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_en_q, irq_en_d, irq_q, irq_d;

    logic [31:0] off_s;
    logic [2:0]  reg_s;
    logic        in_win_s, rd_s, wr_s, unused_s;
    logic        tx_full_s, tx_pop_s, tx_push_req_s, tx_push_s;
    logic        rx_empty_s, rx_pop_req_s, rx_pop_s, rx_push_s;
    logic [TX_W-1:0] tx_head_s;

    // Address decode: offset relative to the base makes the window check a single compare.
    always_comb begin
        off_s         = mem_la_addr - BASE_ADDR;
        in_win_s      = (off_s[31:5] == 27'd0);
        reg_s         = off_s[4:2];
        unused_s      = ^off_s[1:0];
        hit           = in_win_s && (mem_la_read || mem_la_write);
        rd_s          = mem_la_read && in_win_s;
        wr_s          = mem_la_write && in_win_s;
        tx_full_s     = (tx_cnt_q == TX_FULL);
        tx_valid      = (tx_cnt_q != {TX_CW{1'b0}});
        tx_pop_s      = tx_valid && tx_ready;
        tx_push_req_s = wr_s && (reg_s == REG_TX_DATA);
        // A full FIFO still accepts a push when the router drains the head this cycle.
        tx_push_s     = tx_push_req_s && (!tx_full_s || tx_pop_s);
        rx_empty_s    = (rx_cnt_q == {RX_CW{1'b0}});
        rx_ready      = (rx_cnt_q != RX_FULL);
        rx_push_s     = rx_valid && rx_ready;
        rx_pop_req_s  = rd_s && (reg_s == REG_RX_DATA);
        rx_pop_s      = rx_pop_req_s && !rx_empty_s;
        tx_head_s     = tx_mem_q[tx_rptr_q];
        tx_data       = tx_head_s[31:0];
        tx_y_dest     = tx_head_s[32 +: COORD_BITS];
        tx_x_dest     = tx_head_s[32 + COORD_BITS +: COORD_BITS];
        rdata         = rdata_q;
        led           = led_q;
        irq           = irq_q;
    end

    // Next-state for FIFOs, CPU registers, sticky flags and the read data register.
    always_comb begin
        tx_x_d    = tx_x_q;
        tx_y_d    = tx_y_q;
        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_ovf_d  = tx_ovf_q;
        rx_unf_d  = rx_unf_q;
        led_d     = led_q;
        irq_en_d  = irq_en_q;
        rdata_d   = 32'd0;

        if (tx_push_s) begin
            tx_mem_d[tx_wptr_q] = {tx_x_q, tx_y_q, mem_la_wdata};
            tx_wptr_d           = tx_wptr_q + TX_PW'(1);
        end else begin
            tx_wptr_d = tx_wptr_q;
        end
        if (tx_pop_s) begin
            tx_rptr_d = tx_rptr_q + TX_PW'(1);
        end else begin
            tx_rptr_d = tx_rptr_q;
        end
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_push_s) begin
            rx_mem_d[rx_wptr_q] = rx_data;
            rx_wptr_d           = rx_wptr_q + RX_PW'(1);
        end else begin
            rx_wptr_d = rx_wptr_q;
        end
        if (rx_pop_s) begin
            rx_rptr_d = rx_rptr_q + RX_PW'(1);
        end else begin
            rx_rptr_d = rx_rptr_q;
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        // CPU writes; clears are applied before new error events so a fresh event wins.
        if (wr_s) begin
            case (reg_s)
                REG_TX_X:   tx_x_d = mem_la_wdata[COORD_BITS-1:0];
                REG_TX_Y:   tx_y_d = mem_la_wdata[COORD_BITS-1:0];
                REG_STATUS: begin
                    if (mem_la_wdata[2]) tx_ovf_d = 1'b0; else tx_ovf_d = tx_ovf_q;
                    if (mem_la_wdata[3]) rx_unf_d = 1'b0; else rx_unf_d = rx_unf_q;
                end
                REG_LED:    led_d = mem_la_wdata[LED_COUNT-1:0];
`ifdef NOC_MMIO_IRQ_EN
                REG_IRQ_EN: irq_en_d = mem_la_wdata[0];
`endif
                default:    led_d = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        if (tx_push_req_s && !tx_push_s) tx_ovf_d = 1'b1; else tx_ovf_d = tx_ovf_d;
        if (rx_pop_req_s && rx_empty_s)  rx_unf_d = 1'b1; else rx_unf_d = rx_unf_d;

        if (rd_s) begin
            case (reg_s)
                REG_TX_X:    rdata_d[COORD_BITS-1:0] = tx_x_q;
                REG_TX_Y:    rdata_d[COORD_BITS-1:0] = tx_y_q;
                REG_RX_DATA: rdata_d = rx_empty_s ? 32'd0 : rx_mem_q[rx_rptr_q];
                REG_STATUS: begin
                    rdata_d[0]          = !rx_empty_s;
                    rdata_d[1]          = tx_full_s;
                    rdata_d[2]          = tx_ovf_q;
                    rdata_d[3]          = rx_unf_q;
                    rdata_d[8 +: RX_CW]  = rx_cnt_q;
                    rdata_d[16 +: TX_CW] = tx_cnt_q;
                end
                REG_COORD: begin
                    rdata_d[COORD_BITS-1:0]     = MY_X;
                    rdata_d[16 +: COORD_BITS]   = MY_Y;
                end
                REG_LED:     rdata_d[LED_COUNT-1:0] = led_q;
                REG_IRQ_EN:  rdata_d[0] = irq_en_q;
                default:     rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end

        // Interrupt lags the RX state by one cycle; tied low without the feature.
        irq_d = irq_en_q && !rx_empty_s && !unused_s ? 1'b1 : (irq_en_q && !rx_empty_s);
    end

    // State register with synchronous active-low reset; reset drops all buffered messages.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_x_q    <= '0;
            tx_y_q    <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            led_q     <= '0;
            rdata_q   <= 32'd0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
            for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 32'd0;
        end else begin
            tx_x_q    <= tx_x_d;
            tx_y_q    <= tx_y_d;
            tx_mem_q  <= tx_mem_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_mem_q  <= rx_mem_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_unf_q  <= rx_unf_d;
            led_q     <= led_d;
            rdata_q   <= rdata_d;
`ifdef NOC_MMIO_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`else
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_noc_mmio_bridge.sv
// Directed self-checking bench for noc_mmio_bridge (X=1, Y=1, COORD_BITS=1, depths 4).
module tb_noc_mmio_bridge;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX_X   = BASE + 32'h00;
    localparam logic [31:0] A_TX_Y   = BASE + 32'h04;
    localparam logic [31:0] A_TX_D   = BASE + 32'h08;
    localparam logic [31:0] A_RX_D   = BASE + 32'h0C;
    localparam logic [31:0] A_STAT   = BASE + 32'h10;
    localparam logic [31:0] A_COORD  = BASE + 32'h14;
    localparam logic [31:0] A_LED    = BASE + 32'h18;
    localparam logic [31:0] A_IRQEN  = BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_la_read = 1'b0, mem_la_write = 1'b0;
    logic [31:0] mem_la_addr = 32'd0, mem_la_wdata = 32'd0;
    logic        hit;
    logic [31:0] rdata, tx_data;
    logic [0:0]  tx_x_dest, tx_y_dest;
    logic        tx_valid, tx_ready = 1'b0;
    logic [31:0] rx_data = 32'd0;
    logic        rx_valid = 1'b0, rx_ready;
    logic [3:0]  led;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    noc_mmio_bridge #(
        .COORD_BITS(1), .X_COORD(1), .Y_COORD(1), .TX_DEPTH(4), .RX_DEPTH(4),
        .LED_COUNT(4), .BASE_ADDR(32'h1000_0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .mem_la_read(mem_la_read), .mem_la_write(mem_la_write),
        .mem_la_addr(mem_la_addr), .mem_la_wdata(mem_la_wdata), .hit(hit), .rdata(rdata),
        .tx_data(tx_data), .tx_x_dest(tx_x_dest), .tx_y_dest(tx_y_dest), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        mem_la_addr  = addr;
        mem_la_wdata = data;
        mem_la_write = 1'b1;
        tick();
        mem_la_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data);
        mem_la_addr = addr;
        mem_la_read = 1'b1;
        tick();
        mem_la_read = 1'b0;
        data = rdata;
    endtask

    task automatic rx_push(input logic [31:0] data);
        rx_valid = 1'b1;
        rx_data  = data;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_q [4];

        // Reset
        repeat (3) tick();
        reset_n = 1'b1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        cpu_read(A_STAT, rd);   check("rst_status", rd, 32'h0000_0000);
        cpu_read(A_COORD, rd);  check("coord", rd, 32'h0001_0001);

        // Hit decode at both edges of the window
        mem_la_addr = BASE + 32'h1C; mem_la_read = 1'b1; #1;
        check("hit_top", 32'(hit), 32'd1);
        mem_la_addr = BASE + 32'h20; #1;
        check("hit_above", 32'(hit), 32'd0);
        mem_la_addr = BASE - 32'h4; #1;
        check("hit_below", 32'(hit), 32'd0);
        mem_la_read = 1'b0; mem_la_addr = BASE; #1;
        check("hit_idle", 32'(hit), 32'd0);
        tick();

        // Single TX message held while router stalls
        cpu_write(A_TX_X, 32'd1);
        cpu_write(A_TX_Y, 32'd0);
        cpu_write(A_TX_D, 32'hDEAD_BEEF);
        check("tx_valid_1", 32'(tx_valid), 32'd1);
        check("tx_data_1", tx_data, 32'hDEAD_BEEF);
        check("tx_x_1", 32'(tx_x_dest), 32'd1);
        check("tx_y_1", 32'(tx_y_dest), 32'd0);
        tick();
        check("tx_hold", tx_data, 32'hDEAD_BEEF);
        cpu_read(A_TX_X, rd);   check("rd_tx_x", rd, 32'd1);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("tx_valid_pop", 32'(tx_valid), 32'd0);

        // Overflow, W1C, push-while-full accepted with concurrent pop
        for (int i = 1; i <= 5; i++) cpu_write(A_TX_D, 32'(i));
        cpu_read(A_STAT, rd);   check("tx_ovf_status", rd, 32'h0004_0006);
        check("tx_head_full", tx_data, 32'd1);
        cpu_write(A_STAT, 32'h0000_0004);
        cpu_read(A_STAT, rd);   check("tx_ovf_clr", rd, 32'h0004_0002);
        mem_la_addr = A_TX_D; mem_la_wdata = 32'd6; mem_la_write = 1'b1; tx_ready = 1'b1;
        tick();
        mem_la_write = 1'b0; tx_ready = 1'b0;
        cpu_read(A_STAT, rd);   check("tx_full_pushpop", rd, 32'h0004_0002);
        exp_q[0] = 32'd2; exp_q[1] = 32'd3; exp_q[2] = 32'd4; exp_q[3] = 32'd6;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tx_drain_%0d", i), tx_data, exp_q[i]);
            tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        end
        check("tx_empty", 32'(tx_valid), 32'd0);

        // RX fill, ordered drain, underflow
        for (int i = 1; i <= 4; i++) begin
            rx_valid = 1'b1; rx_data = 32'(i * 17); tick();
        end
        rx_valid = 1'b0;
        check("rx_ready_full", 32'(rx_ready), 32'd0);
        cpu_read(A_STAT, rd);   check("rx_full_status", rd, 32'h0000_0401);
        for (int i = 1; i <= 4; i++) begin
            cpu_read(A_RX_D, rd);
            check($sformatf("rx_pop_%0d", i), rd, 32'(i * 17));
            if (i == 1) check("rx_ready_after_pop", 32'(rx_ready), 32'd1);
        end
        cpu_read(A_RX_D, rd);   check("rx_underflow_data", rd, 32'd0);
        cpu_read(A_STAT, rd);   check("rx_underflow_status", rd, 32'h0000_0008);
        cpu_write(A_STAT, 32'h0000_0008);
        cpu_read(A_STAT, rd);   check("rx_unf_clr", rd, 32'h0000_0000);

        // Simultaneous CPU pop and network push at count 2
        rx_push(32'hA1);
        rx_push(32'hA2);
        mem_la_addr = A_RX_D; mem_la_read = 1'b1; rx_valid = 1'b1; rx_data = 32'hA3;
        tick();
        mem_la_read = 1'b0; rx_valid = 1'b0;
        check("rx_simul_data", rdata, 32'hA1);
        cpu_read(A_STAT, rd);   check("rx_simul_count", rd, 32'h0000_0201);
        cpu_read(A_RX_D, rd);   check("rx_simul_a2", rd, 32'hA2);
        cpu_read(A_RX_D, rd);   check("rx_simul_a3", rd, 32'hA3);

        // LED register and out-of-window accesses
        cpu_write(A_LED, 32'hFFFF_FFF5);
        check("led_out", 32'(led), 32'h5);
        cpu_read(A_LED, rd);    check("led_read", rd, 32'h5);
        cpu_write(BASE + 32'h38, 32'hA);
        check("led_outside_wr", 32'(led), 32'h5);
        cpu_read(BASE + 32'h38, rd); check("rd_outside", rd, 32'd0);

`ifdef NOC_MMIO_IRQ_EN
        cpu_write(A_IRQEN, 32'd1);
        cpu_read(A_IRQEN, rd);  check("irqen_read", rd, 32'd1);
        rx_push(32'h55);
        check("irq_lag", 32'(irq), 32'd0);
        tick();
        check("irq_set", 32'(irq), 32'd1);
        cpu_read(A_RX_D, rd);   check("irq_pop_data", rd, 32'h55);
        check("irq_still", 32'(irq), 32'd1);
        tick();
        check("irq_clear", 32'(irq), 32'd0);
`else
        cpu_write(A_IRQEN, 32'd1);
        cpu_read(A_IRQEN, rd);  check("irqen_absent", rd, 32'd0);
        rx_push(32'h55);
        tick();
        check("irq_tied", 32'(irq), 32'd0);
        cpu_read(A_RX_D, rd);   check("irq_pop_data", rd, 32'h55);
`endif

        // Reset with buffered traffic
        cpu_write(A_TX_D, 32'h1234);
        rx_push(32'h77);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        check("rst2_tx_valid", 32'(tx_valid), 32'd0);
        check("rst2_led", 32'(led), 32'd0);
        cpu_read(A_STAT, rd);   check("rst2_status", rd, 32'h0000_0000);
        cpu_read(A_TX_X, rd);   check("rst2_tx_x", rd, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
